// File: rtl/nmr_voter_monitor.sv
// rtl/nmr_voter_monitor.sv - N-modular OBI request voter with per-hart health FSMs and fault exclusion
package nmr_voter_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
        logic        req;
    } obi_req_t;
endpackage

module nmr_voter_monitor #(
    parameter type obi_req_t = nmr_voter_pkg::obi_req_t,
    parameter int  NHARTS    = 3,
    parameter int  NBUS      = 2,
    parameter int  FAULT_THR = 4,
    parameter int  CNT_W     = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  obi_req_t [NBUS-1:0][NHARTS-1:0]  core_req_i,
    output obi_req_t [NBUS-1:0]              voted_req_o,
    input  logic                             enable_i,
    input  logic                             clear_i,
    output logic                             error_o,
    output logic [NHARTS-1:0]                error_id_o,
    output logic [NHARTS-1:0]                fault_o,
    output logic                             fatal_o,
    output logic [NHARTS-1:0][CNT_W-1:0]     mismatch_cnt_o
);
    localparam int W     = $bits(obi_req_t);
    localparam int RUN_W = $clog2(FAULT_THR + 1);
    localparam int IDX_W = $clog2(NHARTS);

    typedef enum logic [1:0] {HEALTHY, SUSPECT, FAULTY} state_t;

    state_t             state_q [NHARTS];
    state_t             state_d [NHARTS];
    logic [RUN_W-1:0]   run_q   [NHARTS];
    logic [RUN_W-1:0]   run_d   [NHARTS];
    logic [NHARTS-1:0]  active;
    logic [NHARTS-1:0]  mis;
    logic [IDX_W-1:0]   first_idx;
    logic [W-1:0]       core_flat  [NBUS][NHARTS];
    logic [W-1:0]       voted_bits [NBUS];
    logic               sample;
    logic               fatal_set;
    int                 n_active;
    int                 ones;
    int                 remaining;
    int                 new_run;

    always_comb begin
        for (int h = 0; h < NHARTS; h++) begin
            fault_o[h] = (state_q[h] == FAULTY);
        end
        active = ~fault_o;
    end

    always_comb begin
        n_active  = 0;
        first_idx = '0;
        for (int h = NHARTS - 1; h >= 0; h--) begin
            if (active[h]) begin
                n_active  = n_active + 1;
                first_idx = IDX_W'(h);
            end
        end
    end

    // Per-bit majority over the active set; an even split defers to the lowest active hart.
    always_comb begin
        ones = 0;
        for (int b = 0; b < NBUS; b++) begin
            for (int h = 0; h < NHARTS; h++) begin
                core_flat[b][h] = core_req_i[b][h];
            end
            for (int i = 0; i < W; i++) begin
                ones = 0;
                for (int h = 0; h < NHARTS; h++) begin
                    if (active[h] && core_flat[b][h][i]) begin
                        ones = ones + 1;
                    end
                end
                if (ones * 2 > n_active) begin
                    voted_bits[b][i] = 1'b1;
                end else if (ones * 2 == n_active) begin
                    voted_bits[b][i] = core_flat[b][first_idx][i];
                end else begin
                    voted_bits[b][i] = 1'b0;
                end
            end
            voted_req_o[b] = obi_req_t'(voted_bits[b]);
        end
    end

    always_comb begin
        mis    = '0;
        sample = 1'b0;
        for (int b = 0; b < NBUS; b++) begin
            if (voted_req_o[b].req) begin
                sample = enable_i;
                for (int h = 0; h < NHARTS; h++) begin
                    if (active[h] &&
                        (((core_req_i[b][h].addr != voted_req_o[b].addr) && core_req_i[b][h].req) ||
                         ((core_req_i[b][h].wdata != voted_req_o[b].wdata) && core_req_i[b][h].we) ||
                         (core_req_i[b][h].be != voted_req_o[b].be) ||
                         (core_req_i[b][h].we != voted_req_o[b].we) ||
                         (core_req_i[b][h].req != voted_req_o[b].req))) begin
                        mis[h] = 1'b1;
                    end
                end
            end
        end
    end

    // Harts are promoted to FAULTY in index order; a promotion that would drop below two voters is refused.
    always_comb begin
        remaining = n_active;
        new_run   = 0;
        fatal_set = 1'b0;
        for (int h = 0; h < NHARTS; h++) begin
            state_d[h] = state_q[h];
            run_d[h]   = run_q[h];
            if (sample && state_q[h] != FAULTY) begin
                if (mis[h]) begin
                    new_run = (state_q[h] == HEALTHY) ? 1 : int'(run_q[h]) + 1;
                    if (new_run >= FAULT_THR) begin
                        if (remaining > 2) begin
                            state_d[h] = FAULTY;
                            run_d[h]   = '0;
                            remaining  = remaining - 1;
                        end else begin
                            state_d[h] = SUSPECT;
                            run_d[h]   = RUN_W'(FAULT_THR);
                            fatal_set  = 1'b1;
                        end
                    end else begin
                        state_d[h] = SUSPECT;
                        run_d[h]   = RUN_W'(new_run);
                    end
                end else begin
                    state_d[h] = HEALTHY;
                    run_d[h]   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            for (int h = 0; h < NHARTS; h++) begin
                state_q[h]        <= HEALTHY;
                run_q[h]          <= '0;
                mismatch_cnt_o[h] <= '0;
            end
            error_id_o <= '0;
            error_o    <= 1'b0;
            fatal_o    <= 1'b0;
        end else begin
            for (int h = 0; h < NHARTS; h++) begin
                state_q[h] <= state_d[h];
                run_q[h]   <= run_d[h];
                if (sample && mis[h] && (mismatch_cnt_o[h] != {CNT_W{1'b1}})) begin
                    mismatch_cnt_o[h] <= mismatch_cnt_o[h] + 1'b1;
                end
            end
            error_id_o <= mis & {NHARTS{enable_i}};
            error_o    <= |(mis & {NHARTS{enable_i}});
            if (fatal_set) begin
                fatal_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nmr_voter_monitor.sv
// tb/tb_nmr_voter_monitor.sv - self-checking bench for nmr_voter_monitor against a behavioural model
module tb_nmr_voter_monitor;
    import nmr_voter_pkg::*;

    localparam int THR = 4;

    logic clk = 1'b0;
    logic rst_n, enable, clear;
    obi_req_t [1:0][2:0] core;
    obi_req_t [1:0] voted, voted2;
    logic err, err2, fatal, fatal2;
    logic [2:0] errid, errid2, fault, fault2;
    logic [2:0][7:0] cnt8;
    logic [2:0][1:0] cnt2;

    int checks = 0;
    int errors = 0;

    int m_state [3];
    int m_run   [3];
    int m_cnt8  [3];
    int m_cnt2  [3];
    logic m_fatal, m_err;
    logic [2:0] m_errid;

    always #5 clk = ~clk;

    nmr_voter_monitor #(.NHARTS(3), .NBUS(2), .FAULT_THR(THR), .CNT_W(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .core_req_i(core), .voted_req_o(voted),
        .enable_i(enable), .clear_i(clear), .error_o(err), .error_id_o(errid),
        .fault_o(fault), .fatal_o(fatal), .mismatch_cnt_o(cnt8)
    );

    nmr_voter_monitor #(.NHARTS(3), .NBUS(2), .FAULT_THR(THR), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .core_req_i(core), .voted_req_o(voted2),
        .enable_i(enable), .clear_i(clear), .error_o(err2), .error_id_o(errid2),
        .fault_o(fault2), .fatal_o(fatal2), .mismatch_cnt_o(cnt2)
    );

    function automatic obi_req_t m_vote(int b);
        logic [$bits(obi_req_t)-1:0] v, x, f;
        int n, first, ones;
        n = 0;
        first = -1;
        v = '0;
        for (int h = 0; h < 3; h++) begin
            if (m_state[h] != 2) begin
                n++;
                if (first < 0) first = h;
            end
        end
        f = (first >= 0) ? core[b][first] : '0;
        for (int i = 0; i < $bits(obi_req_t); i++) begin
            ones = 0;
            for (int h = 0; h < 3; h++) begin
                x = core[b][h];
                if (m_state[h] != 2 && x[i]) ones++;
            end
            v[i] = (2 * ones > n) ? 1'b1 : ((2 * ones == n) ? f[i] : 1'b0);
        end
        return obi_req_t'(v);
    endfunction

    function automatic logic [2:0] m_mis();
        logic [2:0] m;
        obi_req_t v, c;
        m = '0;
        for (int b = 0; b < 2; b++) begin
            v = m_vote(b);
            if (v.req) begin
                for (int h = 0; h < 3; h++) begin
                    c = core[b][h];
                    if (m_state[h] != 2 && ((c.addr != v.addr && c.req) || (c.wdata != v.wdata && c.we) ||
                        c.be != v.be || c.we != v.we || c.req != v.req)) m[h] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    function automatic logic [2:0] m_fault();
        logic [2:0] f;
        for (int h = 0; h < 3; h++) f[h] = (m_state[h] == 2);
        return f;
    endfunction

    task automatic model_clock();
        logic [2:0] mis;
        obi_req_t v0, v1;
        logic smp;
        int rem, nr;
        if (!rst_n || clear) begin
            for (int h = 0; h < 3; h++) begin
                m_state[h] = 0; m_run[h] = 0; m_cnt8[h] = 0; m_cnt2[h] = 0;
            end
            m_fatal = 1'b0; m_err = 1'b0; m_errid = '0;
        end else begin
            mis = m_mis();
            v0 = m_vote(0);
            v1 = m_vote(1);
            smp = enable && (v0.req || v1.req);
            m_errid = enable ? mis : 3'b000;
            m_err = |m_errid;
            if (smp) begin
                rem = 0;
                for (int h = 0; h < 3; h++) if (m_state[h] != 2) rem++;
                for (int h = 0; h < 3; h++) begin
                    if (m_state[h] != 2) begin
                        if (mis[h]) begin
                            nr = (m_state[h] == 0) ? 1 : m_run[h] + 1;
                            if (nr >= THR) begin
                                if (rem - 1 >= 2) begin
                                    m_state[h] = 2; m_run[h] = 0; rem--;
                                end else begin
                                    m_state[h] = 1; m_run[h] = THR; m_fatal = 1'b1;
                                end
                            end else begin
                                m_state[h] = 1; m_run[h] = nr;
                            end
                            if (m_cnt8[h] < 255) m_cnt8[h]++;
                            if (m_cnt2[h] < 3) m_cnt2[h]++;
                        end else begin
                            m_state[h] = 0; m_run[h] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic set_all(input logic [31:0] a);
        for (int h = 0; h < 3; h++) begin
            core[0][h] = '0;
            core[1][h].addr = a; core[1][h].wdata = 32'h0; core[1][h].we = 1'b0;
            core[1][h].be = 4'hf; core[1][h].req = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0; core = '0;
        step(); step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_error got %0b want 0", err); end
        checks++; if (errid !== 3'b000) begin errors++; $display("FAIL reset_error_id got %b want 000", errid); end
        checks++; if (fault !== 3'b000) begin errors++; $display("FAIL reset_fault got %b want 000", fault); end
        checks++; if (fatal !== 1'b0) begin errors++; $display("FAIL reset_fatal got %0b want 0", fatal); end
        checks++; if (cnt8 !== '0) begin errors++; $display("FAIL reset_cnt got %h want 0", cnt8); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        set_all(32'h1000);
        checks++; if (voted[1].addr !== 32'h1000) begin errors++; $display("FAIL equal_vote got %h want 1000", voted[1].addr); end
        step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL equal_error got %0b want 0", err); end
        checks++; if (cnt8 !== '0) begin errors++; $display("FAIL equal_cnt got %h want 0", cnt8); end
        core[1][1].addr = 32'h1004; #1;
        checks++; if (voted[1].addr !== 32'h1000) begin errors++; $display("FAIL single_vote got %h want 1000", voted[1].addr); end
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL single_error got %0b want 1", err); end
        checks++; if (errid !== 3'b010) begin errors++; $display("FAIL single_error_id got %b want 010", errid); end
        checks++; if (cnt8[1] !== 8'd1) begin errors++; $display("FAIL single_cnt1 got %0d want 1", cnt8[1]); end
        set_all(32'h1000);
        step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clean_error got %0b want 0", err); end
    endtask

    task automatic test_fault_tie();
        for (int i = 0; i < 4; i++) begin
            core[1][2].addr = 32'h1000 + 32'((i + 1) * 16); #1;
            step();
            if (i < 3) begin
                checks++; if (fault !== 3'b000) begin errors++; $display("FAIL early_fault step %0d got %b want 000", i, fault); end
            end
        end
        checks++; if (fault !== 3'b100) begin errors++; $display("FAIL thr_fault got %b want 100", fault); end
        checks++; if (cnt8[2] !== 8'd4) begin errors++; $display("FAIL thr_cnt2 got %0d want 4", cnt8[2]); end
        core[1][0].addr = 32'h2000; core[1][1].addr = 32'h3000; #1;
        checks++; if (voted[1].addr !== 32'h2000) begin errors++; $display("FAIL tie_vote got %h want 2000", voted[1].addr); end
        step();
        checks++; if (errid !== 3'b010) begin errors++; $display("FAIL tie_error_id got %b want 010", errid); end
    endtask

    task automatic test_fatal_clear();
        for (int i = 0; i < 4; i++) step();
        checks++; if (fatal !== 1'b1) begin errors++; $display("FAIL fatal_set got %0b want 1", fatal); end
        checks++; if (fault !== 3'b100) begin errors++; $display("FAIL fatal_fault got %b want 100", fault); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (fault !== 3'b000) begin errors++; $display("FAIL clear_fault got %b want 000", fault); end
        checks++; if (fatal !== 1'b0) begin errors++; $display("FAIL clear_fatal got %0b want 0", fatal); end
        checks++; if (cnt8 !== '0) begin errors++; $display("FAIL clear_cnt got %h want 0", cnt8); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear_error got %0b want 0", err); end
    endtask

    task automatic test_saturation();
        logic [5:0] pattern;
        pattern = 6'b110111;
        for (int i = 0; i < 6; i++) begin
            set_all(32'h1000);
            if (pattern[i]) begin core[1][0].addr = 32'h1010; #1; end
            step();
        end
        checks++; if (cnt8[0] !== 8'd5) begin errors++; $display("FAIL sat_cnt8 got %0d want 5", cnt8[0]); end
        checks++; if (cnt2[0] !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d want 3", cnt2[0]); end
        checks++; if (fault !== 3'b000) begin errors++; $display("FAIL sat_fault got %b want 000", fault); end
        core[1][0].addr = 32'h1010; clear = 1'b1; #1;
        step();
        clear = 1'b0;
        checks++; if (cnt8[0] !== 8'd0 || cnt2[0] !== 2'd0) begin errors++; $display("FAIL clr_mis_cnt got %0d/%0d want 0/0", cnt8[0], cnt2[0]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_mis_error got %0b want 0", err); end
    endtask

    task automatic test_gating();
        set_all(32'h1000);
        core[1][1].addr = 32'h1008; enable = 1'b0; #1;
        step();
        enable = 1'b1;
        checks++; if (err !== 1'b0 || cnt8[1] !== 8'd0) begin errors++; $display("FAIL disabled got err %0b cnt %0d want 0/0", err, cnt8[1]); end
        set_all(32'h1000);
        for (int h = 0; h < 3; h++) core[1][h].req = 1'b0;
        core[1][1].we = 1'b1; #1;
        checks++; if (voted[1].req !== 1'b0) begin errors++; $display("FAIL noreq_vote got %0b want 0", voted[1].req); end
        step();
        checks++; if (err !== 1'b0 || cnt8 !== '0) begin errors++; $display("FAIL noreq got err %0b cnt %h want 0", err, cnt8); end
        set_all(32'h1000);
        core[1][2].addr = 32'h1040; #1;
        for (int i = 0; i < 4; i++) step();
        checks++; if (fault !== 3'b100) begin errors++; $display("FAIL gate_fault got %b want 100", fault); end
        core[1][0].addr = 32'h2000; core[1][1].addr = 32'h3000; core[1][2].addr = 32'h3000; #1;
        checks++; if (voted[1].addr !== 32'h2000) begin errors++; $display("FAIL excl_vote got %h want 2000", voted[1].addr); end
        step();
        rst_n = 1'b0;
        step();
        checks++; if (voted[1].addr !== 32'h3000) begin errors++; $display("FAIL rst_vote got %h want 3000", voted[1].addr); end
        checks++; if (fault !== 3'b000 || fatal !== 1'b0 || err !== 1'b0 || cnt8 !== '0) begin
            errors++; $display("FAIL mid_reset got fault %b fatal %0b err %0b cnt %h want zeros", fault, fatal, err, cnt8);
        end
        rst_n = 1'b1;
    endtask

    task automatic gen_random();
        obi_req_t base;
        int hh;
        for (int b = 0; b < 2; b++) begin
            base.addr = $urandom; base.wdata = $urandom; base.we = 1'($urandom);
            base.be = 4'($urandom); base.req = ($urandom_range(0, 3) != 0);
            for (int h = 0; h < 3; h++) core[b][h] = base;
            if ($urandom_range(0, 1) == 0) begin
                hh = $urandom_range(0, 2);
                case ($urandom_range(0, 4))
                    0: core[b][hh].addr = base.addr ^ 32'h10;
                    1: core[b][hh].wdata = base.wdata ^ 32'h1;
                    2: core[b][hh].be = base.be ^ 4'h1;
                    3: core[b][hh].we = ~base.we;
                    default: core[b][hh].req = ~base.req;
                endcase
            end
        end
    endtask

    task automatic test_random();
        obi_req_t ev;
        for (int n = 0; n < 400; n++) begin
            gen_random();
            enable = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 59) == 0);
            rst_n = ($urandom_range(0, 149) != 0);
            #1;
            for (int b = 0; b < 2; b++) begin
                ev = m_vote(b);
                checks++; if (voted[b] !== ev) begin errors++; $display("FAIL rnd_vote cyc %0d bus %0d got %h want %h", n, b, voted[b], ev); end
            end
            step();
            checks++; if (err !== m_err || errid !== m_errid) begin
                errors++; $display("FAIL rnd_error cyc %0d got %0b/%b want %0b/%b", n, err, errid, m_err, m_errid);
            end
            checks++; if (fault !== m_fault() || fault2 !== m_fault()) begin
                errors++; $display("FAIL rnd_fault cyc %0d got %b/%b want %b", n, fault, fault2, m_fault());
            end
            checks++; if (fatal !== m_fatal) begin errors++; $display("FAIL rnd_fatal cyc %0d got %0b want %0b", n, fatal, m_fatal); end
            for (int h = 0; h < 3; h++) begin
                checks++; if (cnt8[h] !== 8'(m_cnt8[h]) || cnt2[h] !== 2'(m_cnt2[h])) begin
                    errors++; $display("FAIL rnd_cnt cyc %0d hart %0d got %0d/%0d want %0d/%0d", n, h, cnt8[h], cnt2[h], m_cnt8[h], m_cnt2[h]);
                end
            end
        end
        rst_n = 1'b1; clear = 1'b0; enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fault_tie();
        test_fatal_clear();
        test_saturation();
        test_gating();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
